// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH synchronous register file with two registered read
// ports and a sequenced clear-all sweep. Define RDL_BYPASS_EN for write-through reads.
module reg_bank #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              wdrop
);

  localparam int unsigned       ADDR_XW  = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = ADDR_XW'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] ptr;

  logic              waddr_ok;
  logic              raddr0_ok;
  logic              raddr1_ok;
  logic              wr_ok;
  logic [WIDTH-1:0]  rd0_next;
  logic [WIDTH-1:0]  rd1_next;

  // Address qualification and next read data (out-of-range reads return 0)
  always_comb begin
    waddr_ok  = {1'b0, waddr}  < DEPTH_X;
    raddr0_ok = {1'b0, raddr0} < DEPTH_X;
    raddr1_ok = {1'b0, raddr1} < DEPTH_X;
    wr_ok     = we && !busy && waddr_ok;
    rd0_next  = raddr0_ok ? mem[raddr0] : '0;
    rd1_next  = raddr1_ok ? mem[raddr1] : '0;
`ifdef RDL_BYPASS_EN
    // Only accepted writes are forwarded; a refused write never reaches a port
    if (wr_ok && (raddr0 == waddr)) rd0_next = wdata;
    if (wr_ok && (raddr1 == waddr)) rd1_next = wdata;
`endif
  end

  // Storage, read registers and the clear-sweep sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '{default: '0};
      rdata0   <= '0;
      rdata1   <= '0;
      state    <= ST_IDLE;
      ptr      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      wdrop    <= 1'b0;
    end else begin
      rdata0   <= rd0_next;
      rdata1   <= rd1_next;
      wdrop    <= we && busy;
      clr_done <= 1'b0;

      if (wr_ok) mem[waddr] <= wdata;

      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_SWEEP;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        ST_SWEEP: begin
          mem[ptr] <= '0;
          if (ptr == LAST_PTR) begin
            state    <= ST_DONE;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          ptr   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Sweep pointer stays inside the array; done only ever pulses while busy
  a_ptr_range : assert property (@(posedge clk) disable iff (rst) {1'b0, ptr} < DEPTH_X);
  a_done_busy : assert property (@(posedge clk) disable iff (rst) clr_done |-> busy);

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: scoreboard bench for reg_bank (DEPTH=16 and DEPTH=10 instances).
// Honours RDL_BYPASS_EN for the same-cycle read/write expectation.
module tb_reg_bank;

  localparam int unsigned W   = 8;
  localparam int unsigned D   = 16;
  localparam int unsigned DB  = 10;
  localparam int unsigned AW  = $clog2(D);
  localparam int unsigned AWB = $clog2(DB);

  logic          clk = 1'b0;
  logic          rst;
  logic          we, we_b;
  logic [AW-1:0] waddr, raddr0, raddr1;
  logic [AWB-1:0] waddr_b, raddr0_b, raddr1_b;
  logic [W-1:0]  wdata, wdata_b;
  logic [W-1:0]  rdata0, rdata1, rdata0_b, rdata1_b;
  logic          clr_req, clr_req_b;
  logic          busy, clr_done, wdrop;
  logic          busy_b, clr_done_b, wdrop_b;

  typedef struct {
    string      tag;
    bit         on_b;
    logic [7:0] e0;
    logic [7:0] e1;
  } rd_exp_t;

  rd_exp_t    sbq[$];
  logic [7:0] m [D];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         busy_cnt, done_cnt;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wdrop(wdrop)
  );

  reg_bank #(.WIDTH(W), .DEPTH(DB)) dut_b (
    .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .raddr0(raddr0_b), .raddr1(raddr1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .clr_req(clr_req_b), .busy(busy_b), .clr_done(clr_done_b), .wdrop(wdrop_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mexp(input int a);
    return (a < 16) ? m[a[3:0]] : 8'h00;
  endfunction

  task automatic expect_rd(input string tag, input bit on_b, input logic [7:0] e0,
                           input logic [7:0] e1);
    rd_exp_t e;
    e.tag = tag; e.on_b = on_b; e.e0 = e0; e.e1 = e1;
    sbq.push_back(e);
  endtask

  // One clock edge; score any read expected at this edge
  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.on_b) begin
        check({e.tag, "/rdata0"}, 32'(rdata0_b), 32'(e.e0));
        check({e.tag, "/rdata1"}, 32'(rdata1_b), 32'(e.e1));
      end else begin
        check({e.tag, "/rdata0"}, 32'(rdata0), 32'(e.e0));
        check({e.tag, "/rdata1"}, 32'(rdata1), 32'(e.e1));
      end
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    we = 1'b1; waddr = 4'(a); wdata = d;
    tick();
    we = 1'b0;
    if (a < 16) m[a[3:0]] = d;
  endtask

  task automatic rd(input string tag, input int a0, input int a1);
    raddr0 = 4'(a0); raddr1 = 4'(a1);
    expect_rd(tag, 1'b0, mexp(a0), mexp(a1));
    tick();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 8; i++) rd(tag, i, i + 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0; clr_req = 1'b0;
    we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr0_b = '0; raddr1_b = '0; clr_req_b = 1'b0;
    clear_model();
    tick(); tick();
    rst = 1'b0;

    // Reset clears storage, read registers and status
    for (int i = 0; i < 16; i++) wr(i, 8'hA5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    check("rst/busy", 32'(busy), 32'(0));
    check("rst/clr_done", 32'(clr_done), 32'(0));
    check("rst/wdrop", 32'(wdrop), 32'(0));
    check("rst/rdata0", 32'(rdata0), 32'(0));
    check("rst/rdata1", 32'(rdata1), 32'(0));
    read_all("rst_read");

    // Basic write then read on both ports
    wr(5, 8'h3C);
    check("basic/wdrop", 32'(wdrop), 32'(0));
    rd("basic", 5, 5);

    // Same-edge write and read of one address
    wr(7, 8'h11);
    we = 1'b1; waddr = 4'd7; wdata = 8'h22; raddr0 = 4'd7; raddr1 = 4'd7;
`ifdef RDL_BYPASS_EN
    e = 8'h22;
`else
    e = 8'h11;
`endif
    expect_rd("conflict", 1'b0, e, e);
    tick();
    we = 1'b0;
    m[7] = 8'h22;
    rd("conflict_next", 7, 7);

    // Full sweep: busy window, done pulse, refused write, reads during sweep
    for (int i = 0; i < 16; i++) wr(i, 8'hFF);
    raddr0 = 4'd10; raddr1 = 4'd15; clr_req = 1'b1;
    expect_rd("sweep_e0", 1'b0, 8'hFF, 8'hFF);
    tick();
    clr_req = 1'b0;
    check("sweep/busy_rise", 32'(busy), 32'(1));
    busy_cnt = int'(busy); done_cnt = int'(clr_done);
    for (int j = 1; j <= 20; j++) begin
      we = (j == 4); waddr = 4'd15; wdata = 8'hAB;
      expect_rd("sweep_rd", 1'b0, (j <= 11) ? 8'hFF : 8'h00, (j <= 16) ? 8'hFF : 8'h00);
      tick();
      check("sweep/busy", 32'(busy), 32'(j <= 16));
      check("sweep/clr_done", 32'(clr_done), 32'(j == 16));
      check("sweep/wdrop", 32'(wdrop), 32'(j == 4));
      busy_cnt += int'(busy); done_cnt += int'(clr_done);
    end
    we = 1'b0;
    check("sweep/busy_cycles", 32'(busy_cnt), 32'(17));
    check("sweep/done_pulses", 32'(done_cnt), 32'(1));
    clear_model();
    read_all("post_sweep");

    // Request held through the sweep, with a write to entry 0 on the request edge
    raddr0 = 4'd1; raddr1 = 4'd1; clr_req = 1'b1;
    we = 1'b1; waddr = 4'd0; wdata = 8'h5A;
    expect_rd("held_e0", 1'b0, 8'h00, 8'h00);
    tick();
    we = 1'b0;
    check("held/wdrop", 32'(wdrop), 32'(0));
    busy_cnt = int'(busy); done_cnt = int'(clr_done);
    raddr0 = 4'd0; raddr1 = 4'd0;
    for (int j = 1; j <= 20; j++) begin
      clr_req = (j <= 16);
      expect_rd("held_rd", 1'b0, (j == 1) ? 8'h5A : 8'h00, (j == 1) ? 8'h5A : 8'h00);
      tick();
      busy_cnt += int'(busy); done_cnt += int'(clr_done);
    end
    clr_req = 1'b0;
    check("held/busy_cycles", 32'(busy_cnt), 32'(17));
    check("held/done_pulses", 32'(done_cnt), 32'(1));
    rd("held_entry0", 0, 0);

    // Non-power-of-two depth: out-of-range write ignored, out-of-range read is 0
    we_b = 1'b1; waddr_b = 4'd12; wdata_b = 8'h77;
    tick();
    check("d10/wdrop_oob", 32'(wdrop_b), 32'(0));
    waddr_b = 4'd9; wdata_b = 8'h66;
    tick();
    we_b = 1'b0;
    raddr0_b = 4'd12; raddr1_b = 4'd9;
    expect_rd("d10_rd", 1'b1, 8'h00, 8'h66);
    tick();
    raddr0_b = 4'd2; raddr1_b = 4'd4;
    expect_rd("d10_alias", 1'b1, 8'h00, 8'h00);
    tick();

    // Reset on the fifth sweep cycle aborts without a done pulse
    for (int i = 0; i < 16; i++) wr(i, 8'hC3);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int j = 1; j <= 4; j++) tick();
    check("abort/busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort/busy", 32'(busy), 32'(0));
    check("abort/clr_done", 32'(clr_done), 32'(0));
    busy_cnt = 0; done_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      busy_cnt += int'(busy); done_cnt += int'(clr_done);
    end
    check("abort/no_busy", 32'(busy_cnt), 32'(0));
    check("abort/no_done", 32'(done_cnt), 32'(0));
    clear_model();
    read_all("abort_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-entry storage bank: the clocked, multi-word successor to the single-bit gated latch with clear. It holds DEPTH words of WIDTH bits, with one write port, two registered read ports, and a sequenced clear-all operation that has a busy/done handshake. It sits between datapath producers and consumers as a small register file. It replaces ad-hoc latch arrays with fully synchronous storage.

## Interface

Parameters:
- WIDTH, 8: data bits per entry (≥1).
- DEPTH, 16: number of entries (≥2; need not be a power of two).
- ADDR_W, $clog2(DEPTH): address width. Derived only; never overridden.

Ports:
- CLK  in  1  clock. One clock domain; all logic is on the rising edge.
- RST  in  1  reset. Synchronous and active-high.
- WE  in  1  write enable.
- WADDR  in  ADDR_W  write address.
- WDATA  in  WIDTH  write data.
- RADDR0  in  ADDR_W  read address, port 0.
- RADDR1  in  ADDR_W  read address, port 1.
- RDATA0  out  WIDTH  registered read data, port 0.
- RDATA1  out  WIDTH  registered read data, port 1.
- CLR_REQ  in  1  request a clear-all sweep (level sampled).
- BUSY  out  1  sweep in progress; writes are refused.
- CLR_DONE  out  1  one-cycle pulse when the sweep completes.
- WDROP  out  1  one-cycle pulse when a write was refused.

## Operation

- Reset (RST=1 at an edge):
  - All entries are set to 0.
  - RDATA0 and RDATA1 are 0.
  - BUSY=0, CLR_DONE=0, WDROP=0.
  - FSM goes to IDLE and the sweep pointer goes to 0.
  - RST overrides every other input, including mid-sweep. Reset mid-sweep aborts the sweep with no CLR_DONE.
- Write:
  - Condition: WE=1, BUSY=0 and WADDR<DEPTH.
  - Effect: mem[WADDR] is set to WDATA at the edge.
- Refused writes:
  - WE=1 with BUSY=1 raises WDROP for 1 cycle. Storage is unchanged.
  - WADDR≥DEPTH: the write is silently ignored and WDROP stays 0.
- Read:
  - At each edge, RDATAn is loaded with mem[RADDRn].
  - RADDRn≥DEPTH returns 0.
  - Reads are always serviced, including during a sweep, and return current contents.
- FSM states and transitions:
  - IDLE → SWEEP on CLR_REQ=1. A write in the same cycle is still performed; the sweep then clears it.
  - SWEEP: BUSY=1. Each cycle clears mem[ptr] and increments ptr. When ptr=DEPTH-1 is cleared, go to DONE.
  - DONE: BUSY=1, CLR_DONE=1 for exactly one cycle, ptr resets to 0, then go to IDLE.
  - CLR_REQ is ignored in SWEEP and DONE. It is not queued.
- Both read ports on the same address return identical data.

## Timing

- Read latency: 1 cycle. RADDR is presented at edge N; data appears on RDATA after edge N.
- Write-to-read: a write at edge N is visible to a read sampled at edge N+1.
- Same-edge read and write to the same address: result depends on RDL_BYPASS_EN (see Configuration).
- Sweep timing, counted from the edge that samples CLR_REQ in IDLE:
  - BUSY rises after that edge.
  - Entries 0..DEPTH-1 clear on the following DEPTH edges.
  - CLR_DONE and BUSY are high for the next cycle.
  - BUSY falls one cycle later.
  - Total BUSY time is DEPTH+1 cycles.
- During the sweep, a read of entry k returns old data until the edge that clears k, and 0 afterwards.
- The sweep pointer is ADDR_W bits wide. It never exceeds DEPTH-1; the reset to 0 happens explicitly in DONE.

## Configuration

- RDL_BYPASS_EN defined (write-through):
  - For an accepted write where RADDRn==WADDR in the same cycle, RDATAn loads WDATA.
  - A refused write is never bypassed.
- RDL_BYPASS_EN undefined (read-before-write): RDATAn loads the old contents of mem[RADDRn].

## Test plan

- Reset: write 0xA5 to every entry, assert RST for 1 cycle → all reads return 0; BUSY=0, CLR_DONE=0, WDROP=0.
- Basic R/W (DEPTH=16, WIDTH=8): write 0x3C to addr 5, read it on port 0 and port 1 the next cycle → both RDATA=0x3C one cycle after the address.
- Same-cycle conflict: mem[7]=0x11, then WE with addr 7 / 0x22 while RADDR0=7:
  - With RDL_BYPASS_EN, RDATA0=0x22.
  - Without it, RDATA0=0x11, and 0x22 appears on the next read.
- Sweep: fill all entries with 0xFF, pulse CLR_REQ:
  - BUSY is high for 17 cycles and CLR_DONE pulses once in the 17th.
  - WE during BUSY → WDROP=1 and the entry stays 0.
  - All entries read 0 after the sweep.
- Boundaries:
  - DEPTH=10: write to addr 12 → ignored, WDROP=0; reading addr 12 returns 0.
  - CLR_REQ held high through the sweep → exactly one sweep.
  - CLR_REQ together with a write to addr 0 → entry 0 ends at 0.
- Reset mid-sweep: assert RST on the 5th SWEEP cycle → BUSY=0 on the next cycle, no CLR_DONE, all entries 0.
